spi_master_ctrl: RTL and testbench

SPI bus master that sits directly upstream of the team's SPI slave and drives its Clock, Mode, MOSI, Enable and Slave_Select inputs while consuming its MISO output. A host issues one-byte full-duplex transfers with a Start/Busy/Done handshake. The block generates SCLK from the system clock and frames each transfer with an active-low per-slave select. Bits are sent and received LSB first, which matches the slave's {MOSI, SR[7:1]} shift direction.

---
 rtl/spi_master_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: one-byte full-duplex SPI master, LSB first, with a
// Start/Busy/Done host handshake and active-low per-slave selects.
// Build macro SPI_LOOPBACK_EN: receive data comes from the registered MOSI.
// In that build the external MISO is ignored and the selects stay inactive.
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned SEL_W      = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            Mode,
  input  logic [SEL_W-1:0]      Slave_Id,
  input  logic [7:0]            Tx_Data,
  output logic [7:0]            Rx_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err,
  output logic                  SCLK,
  output logic [1:0]            Mode_Out,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  Enable,
  output logic [NUM_SLAVES-1:0] Slave_Select
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned TGL_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [TGL_W-1:0]        tgl_q, tgl_d;
  logic [1:0]              mode_q, mode_d;
  logic [7:0]              tx_q, tx_d;
  logic [7:0]              rx_sr_q, rx_sr_d;
  logic [7:0]              rx_data_q, rx_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    en_q, en_d;
  logic [NUM_SLAVES-1:0]   ss_q, ss_d;

  logic                    miso_src;
  logic                    bus_en;
  logic                    phase_q;
  logic                    div_last;
  logic [2:0]              drv_idx;

  // Receive source: looped-back MOSI or the external slave
`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign miso_src    = mosi_q;
  assign bus_en      = 1'b0;
`else
  assign miso_src    = MISO;
  assign bus_en      = 1'b1;
`endif

  // Phase is set for modes 1 and 2; polarity (idle SCLK) for modes 2 and 3
  assign phase_q  = mode_q[1] ^ mode_q[0];
  assign div_last = (div_q == DIV_LAST);

  // Edges are counted from the idle level: toggles with tgl_q[0]==0 are the
  // leading edges. Phase 0 samples on leading and drives the next bit on
  // trailing (bit 0 is preloaded); phase 1 drives on leading, samples trailing.
  assign drv_idx = phase_q ? tgl_q[3:1] : (tgl_q[3:1] + 3'd1);

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tgl_d     = tgl_q;
    mode_d    = mode_q;
    tx_d      = tx_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    en_d      = en_q;
    ss_d      = ss_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          tx_d    = Tx_Data;
          sclk_d  = Mode[1];
          div_d   = '0;
          tgl_d   = '0;
          rx_sr_d = '0;
          if (32'(Slave_Id) >= NUM_SLAVES) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = SETUP;
            ss_d    = bus_en ? ~(NUM_SLAVES'(1) << Slave_Id) : '1;
            en_d    = bus_en;
            if (!(Mode[1] ^ Mode[0])) begin
              mosi_d = Tx_Data[0];
            end
          end
        end
      end
      SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = XFER;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      XFER: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          tgl_d  = tgl_q + TGL_W'(1);
          if (tgl_q[0] == phase_q) begin
            rx_sr_d = {miso_src, rx_sr_q[7:1]};
          end else if (phase_q || (tgl_q != TGL_W'(15))) begin
            mosi_d = tx_q[drv_idx];
          end
          if (tgl_q == TGL_W'(15)) begin
            state_d = HOLD;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          div_d     = '0;
          state_d   = IDLE;
          ss_d      = '1;
          en_d      = 1'b0;
          mosi_d    = 1'b0;
          busy_d    = 1'b0;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tgl_q     <= '0;
      mode_q    <= '0;
      tx_q      <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      en_q      <= 1'b0;
      ss_q      <= '1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tgl_q     <= tgl_d;
      mode_q    <= mode_d;
      tx_q      <= tx_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      en_q      <= en_d;
      ss_q      <= ss_d;
    end
  end

  assign Rx_Data      = rx_data_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Err          = err_q;
  assign SCLK         = sclk_q;
  assign Mode_Out     = mode_q;
  assign MOSI         = mosi_q;
  assign Enable       = en_q;
  assign Slave_Select = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed bench for spi_master_ctrl with a behavioural
// LSB-first shift-register slave and an expected-result scoreboard.
module tb_spi_master_ctrl;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned NUM_SLAVES = 2;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned XFER_CYC   = 18 * CLK_DIV;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic                  Start;
  logic [1:0]            Mode;
  logic [SEL_W-1:0]      Slave_Id;
  logic [7:0]            Tx_Data;
  logic [7:0]            Rx_Data;
  logic                  Busy;
  logic                  Done;
  logic                  Err;
  logic                  SCLK;
  logic [1:0]            Mode_Out;
  logic                  MOSI;
  logic                  MISO;
  logic                  Enable;
  logic [NUM_SLAVES-1:0] Slave_Select;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_slave_q[$];

  // Slave model state; load requests come from the stimulus block
  logic [7:0]       slave_sr    = 8'h00;
  logic [7:0]       load_val    = 8'h00;
  int               load_req    = 0;
  int               load_seen   = 0;
  logic             prev_sclk   = 1'b0;
  logic             prev_ss_act = 1'b0;
  logic [1:0]       cur_mode    = 2'd0;
  logic [SEL_W-1:0] cur_id      = '0;
  logic             ss_act;

  spi_master_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_W     (SEL_W)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Mode        (Mode),
    .Slave_Id    (Slave_Id),
    .Tx_Data     (Tx_Data),
    .Rx_Data     (Rx_Data),
    .Busy        (Busy),
    .Done        (Done),
    .Err         (Err),
    .SCLK        (SCLK),
    .Mode_Out    (Mode_Out),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .Enable      (Enable),
    .Slave_Select(Slave_Select)
  );

  always #5 Clock = ~Clock;

  function automatic logic pol_of(input logic [1:0] m);
    return (m == 2'd2) || (m == 2'd3);
  endfunction

  function automatic logic phase_of(input logic [1:0] m);
    return (m == 2'd1) || (m == 2'd2);
  endfunction

  function automatic logic [1:0] sel_of(input logic [SEL_W-1:0] id);
    return (id[0]) ? 2'b01 : 2'b10;
  endfunction

  assign ss_act = (Slave_Select[cur_id[0]] == 1'b0);
  assign MISO   = slave_sr[0];

  // Slave: shifts {MOSI, sr[7:1]} on its sample edge (leading for phase 0)
  always @(negedge Clock) begin
    if (load_req != load_seen) begin
      slave_sr  <= load_val;
      load_seen <= load_req;
    end else if (ss_act && prev_ss_act && (SCLK !== prev_sclk)) begin
      if (((SCLK != pol_of(cur_mode)) ? 1'b1 : 1'b0) != phase_of(cur_mode))
        slave_sr <= {MOSI, slave_sr[7:1]};
    end
    prev_sclk   <= SCLK;
    prev_ss_act <= ss_act;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_slave(input logic [7:0] v);
    load_val = v;
    load_req++;
    repeat (2) @(negedge Clock);
  endtask

  // Launch one legal transfer, change Tx_Data after acceptance, await Done
  task automatic run_xfer(input logic [1:0] m, input logic [SEL_W-1:0] id,
                          input logic [7:0] tx, input logic [7:0] exp_rx,
                          input logic [7:0] tx_after, input bit release_start);
    int busy_cnt = 0;
    bit got = 1'b0;
    logic [7:0] er;
    logic [7:0] es;
    exp_rx_q.push_back(exp_rx);
    exp_slave_q.push_back(tx);
    cur_mode = m;
    cur_id   = id;
    Mode     = m;
    Slave_Id = id;
    Tx_Data  = tx;
    Start    = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (i == 0) begin
        if (release_start) Start = 1'b0;
        Tx_Data = tx_after;
        check("busy_start", 32'(Busy), 32'h1);
        check("idle_sclk", 32'(SCLK), 32'(pol_of(m)));
        check("mode_out", 32'(Mode_Out), 32'(m));
        check("select_on", 32'(Slave_Select), 32'(sel_of(id)));
        check("enable_on", 32'(Enable), 32'h1);
      end
      if (Busy) busy_cnt++;
      if (Done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'h1);
    er = exp_rx_q.pop_front();
    es = exp_slave_q.pop_front();
    check("rx_data", 32'(Rx_Data), 32'(er));
    check("slave_got", 32'(slave_sr), 32'(es));
    check("busy_len", 32'(busy_cnt), 32'(XFER_CYC));
    check("err_legal", 32'(Err), 32'h0);
    check("select_off", 32'(Slave_Select), 32'h3);
    check("enable_off", 32'(Enable), 32'h0);
    check("mosi_end", 32'(MOSI), 32'h0);
  endtask

  initial begin
    int done_cnt;
    int edges;
    logic last_sclk;

    Reset    = 1'b1;
    Start    = 1'b0;
    Mode     = 2'd0;
    Slave_Id = '0;
    Tx_Data  = 8'h00;
    repeat (3) @(negedge Clock);
    check("rst_sclk", 32'(SCLK), 32'h0);
    check("rst_select", 32'(Slave_Select), 32'h3);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Done), 32'h0);
    check("rst_err", 32'(Err), 32'h0);
    check("rst_rx", 32'(Rx_Data), 32'h0);
    check("rst_mosi", 32'(MOSI), 32'h0);
    check("rst_enable", 32'(Enable), 32'h0);
    check("rst_mode", 32'(Mode_Out), 32'h0);
    Reset = 1'b0;

    // Idle for 10 cycles: nothing moves
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("idle_done", 32'(done_cnt), 32'h0);
    check("idle_sclk0", 32'(SCLK), 32'h0);
    check("idle_select", 32'(Slave_Select), 32'h3);
    check("idle_busy", 32'(Busy), 32'h0);

    // Mode 0 reference transfer
    load_slave(8'h3C);
    run_xfer(2'd0, 2'd0, 8'hA5, 8'h3C, 8'h00, 1'b1);
    @(negedge Clock);
    check("done_single", 32'(Done), 32'h0);

    // Remaining modes, second slave for the polarity-1 modes
    load_slave(8'h5B);
    run_xfer(2'd1, 2'd0, 8'h81, 8'h5B, 8'hFF, 1'b1);
    load_slave(8'hE4);
    run_xfer(2'd2, 2'd1, 8'h81, 8'hE4, 8'h18, 1'b1);
    load_slave(8'h17);
    run_xfer(2'd3, 2'd1, 8'h81, 8'h17, 8'h66, 1'b1);

    // Illegal slave index: immediate Done+Err, no select, Rx_Data kept
    @(negedge Clock);
    Mode     = 2'd0;
    Slave_Id = 2'd3;
    Tx_Data  = 8'hC9;
    Start    = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("ill_done", 32'(Done), 32'h1);
    check("ill_err", 32'(Err), 32'h1);
    check("ill_busy", 32'(Busy), 32'h0);
    check("ill_select", 32'(Slave_Select), 32'h3);
    check("ill_enable", 32'(Enable), 32'h0);
    check("ill_rx", 32'(Rx_Data), 32'h17);
    @(negedge Clock);
    check("ill_done_end", 32'(Done), 32'h0);
    check("ill_err_end", 32'(Err), 32'h0);

    // Reset at the 5th SCLK edge aborts the transfer
    load_slave(8'h99);
    cur_mode  = 2'd0;
    cur_id    = 2'd0;
    Mode      = 2'd0;
    Slave_Id  = 2'd0;
    Tx_Data   = 8'h77;
    Start     = 1'b1;
    last_sclk = SCLK;
    edges     = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (SCLK !== last_sclk) edges++;
      last_sclk = SCLK;
      if (edges == 5) break;
    end
    check("abort_edges", 32'(edges), 32'h5);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("abort_select", 32'(Slave_Select), 32'h3);
    check("abort_busy", 32'(Busy), 32'h0);
    check("abort_done", 32'(Done), 32'h0);
    check("abort_sclk", 32'(SCLK), 32'h0);
    check("abort_rx", 32'(Rx_Data), 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'h0);

    load_slave(8'h96);
    run_xfer(2'd0, 2'd0, 8'h5A, 8'h96, 8'h00, 1'b1);

    // Start held: second transfer accepted in the Done cycle; slave returns 8'h01
    load_slave(8'hC3);
    run_xfer(2'd0, 2'd0, 8'h01, 8'hC3, 8'hFE, 1'b0);
    run_xfer(2'd0, 2'd0, 8'hFE, 8'h01, 8'h00, 1'b1);

    repeat (5) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
